// File: rtl/multicycle_cpu_core.sv
// multicycle_cpu_core
//   Four-phase (IF/FD/EX/WB) CPU core with 16-bit instructions {op, ra, rb, rd}, a 16-entry
//   register file, carry/overflow flags, single-step support and an absorbing HALT state.
//
// Ports
//   clk         core clock, all state updates on the rising edge
//   reset       synchronous, active-low
//   step_mode   1 = one instruction per step pulse, 0 = free run
//   step        single-cycle pulse that launches the next fetch in step mode
//   imem_req    fetch request, held until imem_valid
//   imem_addr   fetch address (current pc)
//   imem_data   instruction word, qualified by imem_valid
//   imem_valid  fetch complete; may coincide with the first cycle of imem_req
//   dbg_addr    debug read index into the register file
//   dbg_data    combinational read of R[dbg_addr]
//   state       IF=0 FD=1 EX=2 WB=3 HALT=4
//   pc          program counter
//   opcode      IR[15:12]
//   w_reg       EX result register
//   cout, ovf   carry / signed-overflow flags
//   halted      high in HALT
//   instr_done  single-cycle pulse during WB
module multicycle_cpu_core #(
    parameter int unsigned DW   = 8,
    parameter int unsigned PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            step_mode,
    input  logic            step,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    input  logic            imem_valid,
    input  logic [3:0]      dbg_addr,
    output logic [DW-1:0]   dbg_data,
    output logic [2:0]      state,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      opcode,
    output logic [DW-1:0]   w_reg,
    output logic            cout,
    output logic            ovf,
    output logic            halted,
    output logic            instr_done
);

    typedef enum logic [2:0] {
        StIf   = 3'd0,
        StFd   = 3'd1,
        StEx   = 3'd2,
        StWb   = 3'd3,
        StHalt = 3'd4
    } state_e;

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpAdd  = 4'h1;
    localparam logic [3:0] OpLdi  = 4'h2;
    localparam logic [3:0] OpSub  = 4'h3;
    localparam logic [3:0] OpAddi = 4'h4;
    localparam logic [3:0] OpDiv  = 4'h5;
    localparam logic [3:0] OpMul  = 4'h6;
    localparam logic [3:0] OpDec  = 4'h7;
    localparam logic [3:0] OpInc  = 4'h8;
    localparam logic [3:0] OpNor  = 4'h9;
    localparam logic [3:0] OpNand = 4'hA;
    localparam logic [3:0] OpXor  = 4'hB;
    localparam logic [3:0] OpNot  = 4'hC;
    localparam logic [3:0] OpBge  = 4'hD;
    localparam logic [3:0] OpJmp  = 4'hE;
    localparam logic [3:0] OpHalt = 4'hF;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d, w_q, w_d;
    logic            cout_q, cout_d, ovf_q, ovf_d;
    logic            step_seen_q, step_seen_d;
    logic [DW-1:0]   rf_q [16];
    logic            rf_we;

    logic [3:0] op, ra, rb, rd;
    assign op = ir_q[15:12];
    assign ra = ir_q[11:8];
    assign rb = ir_q[7:4];
    assign rd = ir_q[3:0];

    logic [DW-1:0] rb_ext, imm_ext;
    assign rb_ext  = DW'(rb);
    assign imm_ext = DW'(ir_q[11:4]);

    // Fetch is gated by the raw reset input so the request falls as soon as reset is held.
    assign imem_req = reset && (state_q == StIf) && (!step_mode || step_seen_q);

    // ALU: one extra bit on add/sub carries the carry/borrow out.
    logic [DW-1:0] alu_res;
    logic [DW:0]   alu_wide;
    logic          alu_cout, alu_ovf;

    always_comb begin
        alu_res  = '0;
        alu_wide = '0;
        alu_cout = cout_q;
        alu_ovf  = ovf_q;
        unique case (op)
            OpAdd: begin
                alu_wide = {1'b0, a_q} + {1'b0, b_q};
                alu_res  = alu_wide[DW-1:0];
                alu_cout = alu_wide[DW];
                alu_ovf  = (a_q[DW-1] == b_q[DW-1]) && (alu_res[DW-1] != a_q[DW-1]);
            end
            OpLdi: alu_res = imm_ext;
            OpSub: begin
                alu_wide = {1'b0, a_q} - {1'b0, b_q};
                alu_res  = alu_wide[DW-1:0];
                alu_cout = ~alu_wide[DW];
                alu_ovf  = (a_q[DW-1] != b_q[DW-1]) && (alu_res[DW-1] != a_q[DW-1]);
            end
            OpAddi: begin
                alu_wide = {1'b0, a_q} + {1'b0, rb_ext};
                alu_res  = alu_wide[DW-1:0];
                alu_cout = alu_wide[DW];
                alu_ovf  = (a_q[DW-1] == rb_ext[DW-1]) && (alu_res[DW-1] != a_q[DW-1]);
            end
            OpDiv: alu_res = (b_q == '0) ? '1 : a_q / b_q;
            OpMul: alu_res = a_q * b_q;
            OpDec: begin
                alu_wide = {1'b0, b_q} - (DW+1)'(1);
                alu_res  = alu_wide[DW-1:0];
                alu_cout = ~alu_wide[DW];
                alu_ovf  = b_q[DW-1] && !alu_res[DW-1];
            end
            OpInc: begin
                alu_wide = {1'b0, b_q} + (DW+1)'(1);
                alu_res  = alu_wide[DW-1:0];
                alu_cout = alu_wide[DW];
                alu_ovf  = !b_q[DW-1] && alu_res[DW-1];
            end
            OpNor:  alu_res = ~(a_q | b_q);
            OpNand: alu_res = ~(a_q & b_q);
            OpXor:  alu_res = a_q ^ b_q;
            OpNot:  alu_res = ~b_q;
            OpNop, OpBge, OpJmp, OpHalt: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        w_d         = w_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        step_seen_d = step_seen_q;
        rf_we       = 1'b0;
        unique case (state_q)
            StIf: begin
                if (!imem_req && step) begin
                    step_seen_d = 1'b1;
                end
                if (imem_req && imem_valid) begin
                    ir_d        = imem_data;
                    step_seen_d = 1'b0;
                    state_d     = StFd;
                end
            end
            StFd: begin
                a_d     = rf_q[ra];
                b_d     = rf_q[rb];
                state_d = StEx;
            end
            StEx: begin
                w_d     = alu_res;
                cout_d  = alu_cout;
                ovf_d   = alu_ovf;
                state_d = StWb;
            end
            StWb: begin
                rf_we   = (op >= OpAdd) && (op <= OpNot);
                state_d = StIf;
                if (op == OpBge) begin
                    pc_d = (a_q >= b_q) ? pc_q + PC_W'(rd) : pc_q + PC_W'(1);
                end else if (op == OpJmp) begin
                    pc_d = PC_W'(ir_q[11:4]);
                end else if (op == OpHalt) begin
                    state_d = StHalt;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            StHalt: ;
            default: state_d = StIf;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIf;
            pc_q        <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            w_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            step_seen_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            w_q         <= w_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            step_seen_q <= step_seen_d;
            if (rf_we) begin
                rf_q[rd] <= w_q;
            end
        end
    end

    assign imem_addr  = pc_q;
    assign dbg_data   = rf_q[dbg_addr];
    assign state      = state_q;
    assign pc         = pc_q;
    assign opcode     = op;
    assign w_reg      = w_q;
    assign cout       = cout_q;
    assign ovf        = ovf_q;
    assign halted     = (state_q == StHalt);
    assign instr_done = (state_q == StWb);

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// tb_multicycle_cpu_core
//   Instruction-level reference model fed at fetch time; expected results are queued and
//   compared by a monitor on each instr_done pulse and the cycle after it.
module tb_multicycle_cpu_core;
    localparam int unsigned DW   = 8;
    localparam int unsigned PC_W = 8;
    localparam longint Full   = longint'(1) << DW;
    localparam longint PcFull = longint'(1) << PC_W;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            step_mode = 1'b0;
    logic            step = 1'b0;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_data = '0;
    logic            imem_valid = 1'b0;
    logic [3:0]      dbg_addr;
    logic [DW-1:0]   dbg_data;
    logic [2:0]      state;
    logic [PC_W-1:0] pc;
    logic [3:0]      opcode;
    logic [DW-1:0]   w_reg;
    logic            cout, ovf, halted, instr_done;

    always #5 clk = ~clk;

    multicycle_cpu_core #(.DW(DW), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .step_mode(step_mode), .step(step),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
        .imem_valid(imem_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .state(state), .pc(pc), .opcode(opcode), .w_reg(w_reg), .cout(cout), .ovf(ovf),
        .halted(halted), .instr_done(instr_done)
    );

    typedef struct {
        longint op; longint rd; longint w; bit c; bit v; bit wr; longint npc; bit halt;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          n_done = 0;
    logic [15:0] rom [256];
    int          min_delay = 0;
    int          max_delay = 0;
    bit          spurious = 1'b0;

    // Architectural model state
    longint mr [16];
    longint mpc;
    bit     mc, mv, mh;

    logic       main_dbg = 1'b0;
    logic [3:0] main_addr = '0;
    logic [3:0] mon_addr = '0;
    assign dbg_addr = main_dbg ? main_addr : mon_addr;

    task automatic check(input string name, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic longint sgn(input longint x);
        return (x >= Full / 2) ? x - Full : x;
    endfunction

    function automatic exp_t iss(input logic [15:0] ins);
        exp_t   e;
        longint op, ra, rb, rd, a, b, r, sr;
        bit     arith;
        op = longint'(ins[15:12]);
        ra = longint'(ins[11:8]);
        rb = longint'(ins[7:4]);
        rd = longint'(ins[3:0]);
        a = mr[ra];
        b = mr[rb];
        r = 0;
        sr = 0;
        arith = 1'b0;
        case (op)
            1:  begin r = a + b; sr = sgn(a) + sgn(b); arith = 1'b1; mc = (r >= Full); end
            2:  r = longint'(ins[11:4]);
            3:  begin r = a - b; sr = sgn(a) - sgn(b); arith = 1'b1; mc = (a >= b); end
            4:  begin r = a + rb; sr = sgn(a) + rb; arith = 1'b1; mc = (r >= Full); end
            5:  r = (b == 0) ? Full - 1 : a / b;
            6:  r = a * b;
            7:  begin r = b - 1; sr = sgn(b) - 1; arith = 1'b1; mc = (b >= 1); end
            8:  begin r = b + 1; sr = sgn(b) + 1; arith = 1'b1; mc = (r >= Full); end
            9:  r = ~(a | b);
            10: r = ~(a & b);
            11: r = a ^ b;
            12: r = ~b;
            default: r = 0;
        endcase
        r = r & (Full - 1);
        if (arith) mv = (sr > Full / 2 - 1) || (sr < -(Full / 2));
        e.op = op; e.rd = rd; e.w = r; e.c = mc; e.v = mv;
        e.wr = (op >= 1) && (op <= 12);
        if (e.wr) mr[rd] = r;
        e.halt = 1'b0;
        case (op)
            13: mpc = (a >= b) ? (mpc + rd) % PcFull : (mpc + 1) % PcFull;
            14: mpc = longint'(ins[11:4]) % PcFull;
            15: begin mh = 1'b1; e.halt = 1'b1; end
            default: mpc = (mpc + 1) % PcFull;
        endcase
        e.npc = mpc;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mr[i] = 0;
        mpc = 0; mc = 1'b0; mv = 1'b0; mh = 1'b0;
        exp_q.delete();
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (cycles) @(negedge clk);
        reset = 1'b1;
        check("post_reset_state", longint'(state), 0);
        check("post_reset_pc", longint'(pc), 0);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic read_reg(input int idx, output longint val);
        main_addr = 4'(idx);
        main_dbg = 1'b1;
        #1;
        val = longint'(dbg_data);
        main_dbg = 1'b0;
    endtask

    task automatic run_until_halt(input int bound, output int cyc);
        cyc = 0;
        while (!halted && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        check("halt_reached", longint'(halted), 1);
    endtask

    // Instruction memory: random latency, optional junk valid pulses while idle.
    initial begin
        int cnt;
        cnt = -1;
        forever begin
            @(negedge clk);
            #1;
            imem_valid = 1'b0;
            if (reset && imem_req) begin
                if (cnt < 0) cnt = int'($urandom_range(max_delay, min_delay));
                if (cnt == 0) begin
                    check("fetch_addr", longint'(imem_addr), mpc);
                    imem_valid = 1'b1;
                    imem_data = rom[imem_addr];
                    exp_q.push_back(iss(rom[imem_addr]));
                    cnt = -1;
                end else begin
                    cnt--;
                    imem_data = 16'($urandom);
                end
            end else begin
                cnt = -1;
                if (spurious && $urandom_range(3, 0) == 0) begin
                    imem_valid = 1'b1;
                    imem_data = 16'($urandom);
                end
            end
        end
    end

    // Monitor: result/flags in WB, pc/register write/halt the cycle after.
    initial begin
        exp_t e;
        bit   pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                pend = 1'b0;
                continue;
            end
            if (pend) begin
                check("next_pc", longint'(pc), e.npc);
                check("halted", longint'(halted), longint'(e.halt));
                if (e.wr) check("reg_write", longint'(dbg_data), e.w);
                pend = 1'b0;
            end
            if (instr_done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("unexpected_instr_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("opcode", longint'(opcode), e.op);
                    check("w_reg", longint'(w_reg), e.w);
                    check("cout", longint'(cout), longint'(e.c));
                    check("ovf", longint'(ovf), longint'(e.v));
                    mon_addr = 4'(e.rd);
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint v;
        int     cyc, base;

        // Reset in the middle of a slow fetch after some state has been built up.
        min_delay = 6; max_delay = 6; spurious = 1'b0;
        clear_rom();
        rom[0] = 16'h2FF1; rom[1] = 16'h1113;
        apply_reset(2);
        cyc = 0;
        while (!(imem_req && pc == 2) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_second_fetch", longint'(pc), 2);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_state", longint'(state), 0);
        check("rst_pc", longint'(pc), 0);
        check("rst_opcode", longint'(opcode), 0);
        check("rst_w_reg", longint'(w_reg), 0);
        check("rst_cout", longint'(cout), 0);
        check("rst_ovf", longint'(ovf), 0);
        check("rst_halted", longint'(halted), 0);
        check("rst_instr_done", longint'(instr_done), 0);
        check("rst_imem_req", longint'(imem_req), 0);
        @(negedge clk);
        check("rst_imem_req_2", longint'(imem_req), 0);
        for (int i = 0; i < 16; i++) begin
            read_reg(i, v);
            check("rst_regfile", v, 0);
        end

        // Zero-wait program: four instructions, four cycles each.
        min_delay = 0; max_delay = 0;
        clear_rom();
        rom[0] = 16'h2051; rom[1] = 16'h2032; rom[2] = 16'h1124; rom[3] = 16'hF000;
        apply_reset(2);
        run_until_halt(40, cyc);
        check("halt_cycle", cyc, 16);
        repeat (2) @(negedge clk);
        read_reg(1, v); check("prog_r1", v, 5);
        read_reg(2, v); check("prog_r2", v, 3);
        read_reg(4, v); check("prog_r4", v, 8);

        // Carry wrap then signed overflow.
        clear_rom();
        rom[0] = 16'h2FF1; rom[1] = 16'h2012; rom[2] = 16'h1123;
        rom[3] = 16'h27F1; rom[4] = 16'h1124; rom[5] = 16'hF000;
        apply_reset(2);
        run_until_halt(100, cyc);
        repeat (2) @(negedge clk);
        read_reg(3, v); check("wrap_r3", v, 0);
        read_reg(4, v); check("ovf_r4", v, 8'h80);
        check("ovf_cout_final", longint'(cout), 0);
        check("ovf_flag_final", longint'(ovf), 1);

        // Conditional branch taken, then not taken followed by a jump.
        clear_rom();
        rom[0] = 16'h2052; rom[1] = 16'h2033; rom[4] = 16'hD236; rom[10] = 16'hF000;
        apply_reset(2);
        run_until_halt(100, cyc);
        check("bge_taken_pc", longint'(pc), 10);
        clear_rom();
        rom[0] = 16'h2032; rom[1] = 16'h2053; rom[4] = 16'hD236; rom[5] = 16'hE040;
        apply_reset(2);
        base = n_done; cyc = 0;
        while (n_done - base < 6 && cyc < 100) begin
            @(negedge clk);
            #3;
            cyc++;
        end
        @(negedge clk);
        check("jmp_pc", longint'(pc), 4);

        // Single-step: idle until a step pulse, then exactly one instruction.
        step_mode = 1'b1; min_delay = 0; max_delay = 3; spurious = 1'b1;
        clear_rom();
        rom[0] = 16'h2AB3; rom[1] = 16'h1333;
        apply_reset(2);
        repeat (20) begin
            @(negedge clk);
            check("step_idle_state", longint'(state), 0);
            check("step_idle_req", longint'(imem_req), 0);
        end
        base = n_done;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (30) @(negedge clk);
        #3;
        check("step_one_instr", n_done - base, 1);
        check("step_end_state", longint'(state), 0);
        check("step_end_req", longint'(imem_req), 0);
        check("step_end_pc", longint'(pc), 1);
        step_mode = 1'b0;

        // Three-cycle memory latency and divide by zero.
        min_delay = 3; max_delay = 3; spurious = 1'b0;
        clear_rom();
        rom[0] = 16'h2071; rom[1] = 16'h5102; rom[2] = 16'hF000;
        apply_reset(2);
        run_until_halt(100, cyc);
        check("slow_mem_cycles", cyc, 21);
        repeat (2) @(negedge clk);
        read_reg(2, v); check("div_by_zero", v, 8'hFF);

        // Random programs with random latency and junk valid pulses.
        for (int ep = 0; ep < 6; ep++) begin
            min_delay = 0; max_delay = 3; spurious = 1'b1;
            for (int i = 0; i < 256; i++) begin
                logic [3:0]  op4;
                logic [11:0] rest;
                op4 = 4'($urandom_range(14, 0));
                if ($urandom_range(99, 0) == 0) op4 = 4'hF;
                rest = 12'($urandom);
                rom[i] = {op4, rest};
            end
            apply_reset(1 + ep % 2);
            base = n_done; cyc = 0;
            while (!halted && n_done - base < 60 && cyc < 2000) begin
                @(negedge clk);
                #3;
                cyc++;
            end
            check("random_progress", longint'(halted || (n_done - base >= 60)), 1);
            repeat (3) @(negedge clk);
            if (halted) begin
                for (int i = 0; i < 16; i++) begin
                    read_reg(i, v);
                    check("random_final_reg", v, mr[i]);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
